// File: rtl/j1_code_loader_if.sv
// Signal bundle linking the j1 boot loader to its UART byte source, the host,
// the j1 core reset and the code RAM write port.
interface j1_code_loader_if #(
    parameter int ADDR_W = 9
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              host_reboot;
    logic              cpu_resetq;
    logic              code_we;
    logic [ADDR_W-1:0] code_waddr;
    logic [15:0]       code_wdata;
    logic              loading;
    logic              done;
    logic              err;

    // master is the loader; slave is everything around it (byte source, host, core, RAM)
    modport master (
        input  rx_valid, rx_data, host_reboot,
        output rx_ready, cpu_resetq, code_we, code_waddr, code_wdata, loading, done, err
    );

    modport slave (
        output rx_valid, rx_data, host_reboot,
        input  rx_ready, cpu_resetq, code_we, code_waddr, code_wdata, loading, done, err
    );
endinterface

// File: rtl/j1_code_loader.sv
// Boot sequencer for the j1 core: loads a framed, XOR-checked program image from a
// byte stream into code RAM while holding the core in reset, then releases it.
module j1_code_loader #(
    parameter int         ADDR_W      = 9,
    parameter logic [7:0] MAGIC       = 8'hA5,
    parameter int         HOLD_CYCLES = 8,
    parameter int         TIMEOUT     = 100000,
    parameter bit         BOOT_RUN    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    j1_code_loader_if.master bus
);
    localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CKSUM, S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rx_ready;
    logic              r_cpu_resetq;
    logic              r_code_we;
    logic [ADDR_W-1:0] r_code_waddr;
    logic [15:0]       r_code_wdata;
    logic              r_done;
    logic              r_err;
    logic              r_good_load;
    logic [ADDR_W-1:0] r_index;
    logic [15:0]       r_remain;
    logic [7:0]        r_lo;
    logic [7:0]        r_acc;
    logic [HW-1:0]     r_hold_cnt;
    logic [TW-1:0]     r_idle_cnt;

    logic              w_xfer;
    logic              w_magic;
    logic [15:0]       w_count;
    logic              w_count_bad;
    logic              w_last_word;
    logic              w_hold_end;
    logic              w_timeout;
    logic              w_loading;
    logic              w_rx_ready_d;

    assign w_xfer       = bus.rx_valid & r_rx_ready;
    assign w_magic      = w_xfer && (bus.rx_data == MAGIC);
    assign w_count      = {bus.rx_data, r_lo};
    assign w_count_bad  = (w_count == 16'd0) || ({16'd0, w_count} > MAX_WORDS);
    assign w_last_word  = (r_remain == 16'd1);
    assign w_hold_end   = (r_hold_cnt == HW'(HOLD_CYCLES - 1));
    assign w_timeout    = (TIMEOUT != 0) && w_loading && !w_xfer &&
                          (r_idle_cnt == TW'(TIMEOUT - 1));
    assign w_rx_ready_d = (w_next != S_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // MAGIC outranks a simultaneous host_reboot; a timeout overrides any frame progress.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_magic) begin
                    w_next = S_CNT_LO;
                end else if (bus.host_reboot) begin
                    w_next = S_HOLD;
                end
            end
            S_CNT_LO:  if (w_xfer) w_next = S_CNT_HI;
            S_CNT_HI:  if (w_xfer) w_next = w_count_bad ? S_IDLE : S_DATA_LO;
            S_DATA_LO: if (w_xfer) w_next = S_DATA_HI;
            S_DATA_HI: if (w_xfer) w_next = w_last_word ? S_CKSUM : S_DATA_LO;
            S_CKSUM:   if (w_xfer) w_next = (bus.rx_data == r_acc) ? S_HOLD : S_IDLE;
            S_HOLD:    if (w_hold_end) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        w_loading = 1'b0;
        case (r_state)
            S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CKSUM: w_loading = 1'b1;
            default: w_loading = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_ready   <= 1'b0;
            r_cpu_resetq <= BOOT_RUN;
            r_code_we    <= 1'b0;
            r_code_waddr <= '0;
            r_code_wdata <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_good_load  <= 1'b0;
            r_index      <= '0;
            r_remain     <= '0;
            r_lo         <= '0;
            r_acc        <= '0;
            r_hold_cnt   <= '0;
            r_idle_cnt   <= '0;
        end else begin
            r_rx_ready <= w_rx_ready_d;
            r_code_we  <= 1'b0;
            r_done     <= 1'b0;
            if (!w_loading || w_xfer) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_magic) begin
                        r_cpu_resetq <= 1'b0;
                        r_err        <= 1'b0;
                    end else if (bus.host_reboot) begin
                        r_cpu_resetq <= 1'b0;
                        r_good_load  <= 1'b0;
                    end
                end
                S_CNT_LO: begin
                    if (w_xfer) r_lo <= bus.rx_data;
                end
                S_CNT_HI: begin
                    if (w_xfer) begin
                        if (w_count_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_index  <= '0;
                            r_acc    <= '0;
                            r_remain <= w_count;
                        end
                    end
                end
                S_DATA_LO: begin
                    if (w_xfer) begin
                        r_lo  <= bus.rx_data;
                        r_acc <= r_acc ^ bus.rx_data;
                    end
                end
                // The word is written in the cycle after its high byte is accepted.
                S_DATA_HI: begin
                    if (w_xfer) begin
                        r_code_we    <= 1'b1;
                        r_code_waddr <= r_index;
                        r_code_wdata <= {bus.rx_data, r_lo};
                        r_index      <= r_index + ADDR_W'(1);
                        r_remain     <= r_remain - 16'd1;
                        r_acc        <= r_acc ^ bus.rx_data;
                    end
                end
                S_CKSUM: begin
                    if (w_xfer) begin
                        if (bus.rx_data == r_acc) begin
                            r_good_load <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_hold_end) begin
                        r_cpu_resetq <= 1'b1;
                        r_done       <= r_good_load;
                        r_hold_cnt   <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.cpu_resetq = r_cpu_resetq;
    assign bus.code_we    = r_code_we;
    assign bus.code_waddr = r_code_waddr;
    assign bus.code_wdata = r_code_wdata;
    assign bus.loading    = w_loading;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_j1_code_loader.sv
// Self-checking bench for j1_code_loader: scoreboarded code RAM writes plus
// per-scenario checks of reset, load, error, timeout and reboot behaviour.
module tb_j1_code_loader;
    localparam int         ADDR_W  = 9;
    localparam logic [7:0] MAGIC_B = 8'hA5;
    localparam int         HOLD    = 8;
    localparam int         TMO     = 50;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nFails = 0;
    int   cycleCount = 0;
    int   doneCount = 0;
    wr_t  sbQ[$];

    j1_code_loader_if #(.ADDR_W(ADDR_W)) bus();

    j1_code_loader #(
        .ADDR_W(ADDR_W), .MAGIC(MAGIC_B), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .BOOT_RUN(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Every write the DUT makes must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.done === 1'b1) doneCount++;
        if (bus.code_we === 1'b1) begin
            nChecks++;
            if (sbQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         bus.code_waddr, bus.code_wdata);
            end else begin
                wr_t e;
                e = sbQ.pop_front();
                if ({bus.code_waddr, bus.code_wdata} !== e) begin
                    nFails++;
                    $display("[TB] FAIL code_write: got addr=%h data=%h, expected addr=%h data=%h",
                             bus.code_waddr, bus.code_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int k = 0; k < 100 && !sent; k++) begin
            if (bus.rx_ready === 1'b1) sent = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        nChecks++;
        if (!sent) begin
            nFails++;
            $display("[TB] FAIL byte_accept: got rx_ready never high, expected byte %h accepted", b);
        end
    endtask

    task automatic sendImage(input logic [15:0] words[$], input logic [7:0] corrupt,
                             output int resetqHigh, output int loadingLow);
        logic [7:0]  fr[$];
        logic [7:0]  ck;
        logic [15:0] n;
        n  = 16'(words.size());
        ck = 8'h00;
        fr = {MAGIC_B, n[7:0], n[15:8]};
        foreach (words[i]) begin
            logic [15:0] w;
            w = words[i];
            fr.push_back(w[7:0]);
            fr.push_back(w[15:8]);
            ck = ck ^ w[7:0] ^ w[15:8];
            sbQ.push_back({ADDR_W'(i), w});
        end
        fr.push_back(ck ^ corrupt);
        resetqHigh = 0;
        loadingLow = 0;
        foreach (fr[i]) begin
            sendByte(fr[i]);
            if (i < fr.size() - 1) begin
                if (bus.cpu_resetq !== 1'b0) resetqHigh++;
                if (bus.loading !== 1'b1) loadingLow++;
            end
        end
    endtask

    task automatic measureHold(output int lowCycles, output logic doneAtRelease,
                               output int doneInHold, output int readyInHold);
        lowCycles = 0;
        doneAtRelease = 1'b0;
        doneInHold = 0;
        readyInHold = 0;
        for (int k = 0; k < 64; k++) begin
            if (bus.cpu_resetq !== 1'b0) begin
                doneAtRelease = bus.done;
                break;
            end
            lowCycles++;
            if (bus.done === 1'b1) doneInHold++;
            if (bus.rx_ready === 1'b1) readyInHold++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++; if (bus.cpu_resetq !== 1'b1) begin nFails++; $display("[TB] FAIL reset_resetq: got %b, expected 1", bus.cpu_resetq); end
        nChecks++; if (bus.rx_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ready: got %b, expected 0", bus.rx_ready); end
        nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err: got %b, expected 0", bus.err); end
        nChecks++; if (bus.loading !== 1'b0) begin nFails++; $display("[TB] FAIL reset_loading: got %b, expected 0", bus.loading); end
        reset = 1'b0;
        #1;
        nChecks++; if (bus.rx_ready !== 1'b0) begin nFails++; $display("[TB] FAIL ready_before_edge: got %b, expected 0", bus.rx_ready); end
        @(negedge clk);
        nChecks++; if (bus.rx_ready !== 1'b1) begin nFails++; $display("[TB] FAIL ready_after_edge: got %b, expected 1", bus.rx_ready); end
        sendByte(8'h00);
        sendByte(8'h12);
        repeat (3) @(negedge clk);
        nChecks++; if (bus.cpu_resetq !== 1'b1) begin nFails++; $display("[TB] FAIL idle_junk_resetq: got %b, expected 1", bus.cpu_resetq); end
        nChecks++; if (bus.loading !== 1'b0) begin nFails++; $display("[TB] FAIL idle_junk_loading: got %b, expected 0", bus.loading); end
    endtask

    task automatic test_good_load();
        logic [15:0] words[$];
        int rqHigh, ldLow, low, doneHold, readyHold, startCyc;
        logic doneRel;
        words = {16'h1234, 16'h5678};
        startCyc = cycleCount;
        sendImage(words, 8'h00, rqHigh, ldLow);
        nChecks++; if (cycleCount - startCyc != 8) begin nFails++; $display("[TB] FAIL back_to_back_cycles: got %0d, expected 8", cycleCount - startCyc); end
        nChecks++; if (rqHigh != 0) begin nFails++; $display("[TB] FAIL frame_resetq_high: got %0d, expected 0", rqHigh); end
        nChecks++; if (ldLow != 0) begin nFails++; $display("[TB] FAIL frame_loading_low: got %0d, expected 0", ldLow); end
        measureHold(low, doneRel, doneHold, readyHold);
        nChecks++; if (low != HOLD) begin nFails++; $display("[TB] FAIL load_hold_cycles: got %0d, expected %0d", low, HOLD); end
        nChecks++; if (doneRel !== 1'b1) begin nFails++; $display("[TB] FAIL load_done_at_release: got %b, expected 1", doneRel); end
        nChecks++; if (doneHold != 0) begin nFails++; $display("[TB] FAIL load_done_early: got %0d, expected 0", doneHold); end
        nChecks++; if (readyHold != 0) begin nFails++; $display("[TB] FAIL load_ready_in_hold: got %0d, expected 0", readyHold); end
        nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL load_err: got %b, expected 0", bus.err); end
        @(negedge clk);
        nChecks++; if (bus.done !== 1'b0) begin nFails++; $display("[TB] FAIL done_single_pulse: got %b, expected 0", bus.done); end
        nChecks++; if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL load_writes_missing: got %0d pending, expected 0", sbQ.size()); end
    endtask

    task automatic test_bad_checksum();
        logic [15:0] words[$];
        int rqHigh, ldLow, low, doneHold, readyHold, doneBefore;
        logic doneRel;
        words = {16'h1234, 16'h5678};
        sendImage(words, 8'h01, rqHigh, ldLow);
        nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("[TB] FAIL cksum_err: got %b, expected 1", bus.err); end
        nChecks++; if (bus.loading !== 1'b0) begin nFails++; $display("[TB] FAIL cksum_loading: got %b, expected 0", bus.loading); end
        doneBefore = doneCount;
        repeat (20) @(negedge clk);
        nChecks++; if (bus.cpu_resetq !== 1'b0) begin nFails++; $display("[TB] FAIL cksum_core_held: got %b, expected 0", bus.cpu_resetq); end
        nChecks++; if (doneCount != doneBefore) begin nFails++; $display("[TB] FAIL cksum_done: got %0d pulses, expected 0", doneCount - doneBefore); end
        nChecks++; if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL cksum_writes_missing: got %0d pending, expected 0", sbQ.size()); end
        // Second image carries an A5 byte inside the data, which must not resync.
        words = {16'hBEEF, 16'h00A5};
        sendImage(words, 8'h00, rqHigh, ldLow);
        nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL recover_err: got %b, expected 0", bus.err); end
        nChecks++; if (ldLow != 0) begin nFails++; $display("[TB] FAIL recover_loading_low: got %0d, expected 0", ldLow); end
        measureHold(low, doneRel, doneHold, readyHold);
        nChecks++; if (low != HOLD) begin nFails++; $display("[TB] FAIL recover_hold: got %0d, expected %0d", low, HOLD); end
        nChecks++; if (doneRel !== 1'b1) begin nFails++; $display("[TB] FAIL recover_done: got %b, expected 1", doneRel); end
        nChecks++; if (bus.cpu_resetq !== 1'b1) begin nFails++; $display("[TB] FAIL recover_resetq: got %b, expected 1", bus.cpu_resetq); end
    endtask

    task automatic test_bad_count();
        sendByte(MAGIC_B);
        sendByte(8'h00);
        sendByte(8'h00);
        nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("[TB] FAIL count0_err: got %b, expected 1", bus.err); end
        nChecks++; if (bus.loading !== 1'b0) begin nFails++; $display("[TB] FAIL count0_loading: got %b, expected 0", bus.loading); end
        nChecks++; if (bus.rx_ready !== 1'b1) begin nFails++; $display("[TB] FAIL count0_ready: got %b, expected 1", bus.rx_ready); end
        nChecks++; if (bus.cpu_resetq !== 1'b0) begin nFails++; $display("[TB] FAIL count0_resetq: got %b, expected 0", bus.cpu_resetq); end
        sendByte(MAGIC_B);
        nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL magic_clears_err: got %b, expected 0", bus.err); end
        sendByte(8'h01);
        sendByte(8'h02);
        nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("[TB] FAIL count513_err: got %b, expected 1", bus.err); end
        nChecks++; if (bus.loading !== 1'b0) begin nFails++; $display("[TB] FAIL count513_loading: got %b, expected 0", bus.loading); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_max_image();
        logic [15:0] words[$];
        int rqHigh, ldLow, low, doneHold, readyHold;
        logic doneRel;
        for (int i = 0; i < (1 << ADDR_W); i++) words.push_back(16'($urandom));
        sendImage(words, 8'h00, rqHigh, ldLow);
        nChecks++; if (ldLow != 0) begin nFails++; $display("[TB] FAIL max_loading_low: got %0d, expected 0", ldLow); end
        nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL max_err: got %b, expected 0", bus.err); end
        measureHold(low, doneRel, doneHold, readyHold);
        nChecks++; if (doneRel !== 1'b1) begin nFails++; $display("[TB] FAIL max_done: got %b, expected 1", doneRel); end
        nChecks++; if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL max_writes_missing: got %0d pending, expected 0", sbQ.size()); end
    endtask

    task automatic test_timeout();
        int cyc;
        sendByte(MAGIC_B);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h34);
        cyc = 0;
        while (bus.err !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        nChecks++; if (cyc != TMO) begin nFails++; $display("[TB] FAIL timeout_cycles: got %0d, expected %0d", cyc, TMO); end
        nChecks++; if (bus.loading !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_loading: got %b, expected 0", bus.loading); end
        nChecks++; if (bus.cpu_resetq !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_resetq: got %b, expected 0", bus.cpu_resetq); end
    endtask

    task automatic test_reboot();
        int low, doneHold, readyHold;
        logic doneRel;
        bus.host_reboot = 1'b1;
        @(negedge clk);
        bus.host_reboot = 1'b0;
        measureHold(low, doneRel, doneHold, readyHold);
        nChecks++; if (low != HOLD) begin nFails++; $display("[TB] FAIL reboot_hold: got %0d, expected %0d", low, HOLD); end
        nChecks++; if (doneRel !== 1'b0 || doneHold != 0) begin nFails++; $display("[TB] FAIL reboot_done: got %b/%0d, expected 0/0", doneRel, doneHold); end
        nChecks++; if (readyHold != 0) begin nFails++; $display("[TB] FAIL reboot_ready_in_hold: got %0d, expected 0", readyHold); end
        nChecks++; if (bus.cpu_resetq !== 1'b1) begin nFails++; $display("[TB] FAIL reboot_resetq: got %b, expected 1", bus.cpu_resetq); end
    endtask

    task automatic test_reset_midframe();
        bus.host_reboot = 1'b1;
        sendByte(MAGIC_B);
        bus.host_reboot = 1'b0;
        nChecks++; if (bus.loading !== 1'b1 || bus.rx_ready !== 1'b1) begin nFails++; $display("[TB] FAIL magic_beats_reboot: got loading=%b ready=%b, expected 1/1", bus.loading, bus.rx_ready); end
        sendByte(8'h01);
        sendByte(8'h00);
        bus.host_reboot = 1'b1;
        @(negedge clk);
        bus.host_reboot = 1'b0;
        nChecks++; if (bus.loading !== 1'b1 || bus.rx_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reboot_ignored_midframe: got loading=%b ready=%b, expected 1/1", bus.loading, bus.rx_ready); end
        sendByte(8'h34);
        reset = 1'b1;
        #2;
        nChecks++; if (bus.cpu_resetq !== 1'b1) begin nFails++; $display("[TB] FAIL async_resetq: got %b, expected 1", bus.cpu_resetq); end
        nChecks++; if (bus.rx_ready !== 1'b0) begin nFails++; $display("[TB] FAIL async_ready: got %b, expected 0", bus.rx_ready); end
        nChecks++; if (bus.loading !== 1'b0) begin nFails++; $display("[TB] FAIL async_loading: got %b, expected 0", bus.loading); end
        nChecks++; if (bus.code_waddr !== '0 || bus.code_wdata !== 16'h0000) begin nFails++; $display("[TB] FAIL async_code_bus: got addr=%h data=%h, expected 0/0", bus.code_waddr, bus.code_wdata); end
        nChecks++; if (bus.code_we !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL async_flags: got we=%b done=%b err=%b, expected 0/0/0", bus.code_we, bus.done, bus.err); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        nChecks++; if (bus.rx_ready !== 1'b0) begin nFails++; $display("[TB] FAIL rerelease_ready_low: got %b, expected 0", bus.rx_ready); end
        @(negedge clk);
        nChecks++; if (bus.rx_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rerelease_ready_high: got %b, expected 1", bus.rx_ready); end
        nChecks++; if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL midframe_writes_pending: got %0d, expected 0", sbQ.size()); end
    endtask

    initial begin
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.host_reboot = 1'b0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_count();
        test_max_image();
        test_timeout();
        test_reboot();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
